// File: rtl/st_pattern_source.sv
// st_pattern_source: software-triggered streaming packet generator.
// Emits LEN beats of deterministic per-lane data with sop/eop framing on a
// valid/ready interface. Status outputs are busy/done and a beat counter.
// DATA_WIDTH must be a multiple of 32; each 32-bit lane carries one pattern word.
module st_pattern_source #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] st_data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  sop,
    output logic                  eop,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  beats_sent
);

    localparam int unsigned LANES = DATA_WIDTH / 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q,  state_d;
    logic [LEN_WIDTH-1:0]  len_q,    len_d;
    logic [1:0]            mode_q,   mode_d;
    logic [LEN_WIDTH-1:0]  beats_q,  beats_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic                  valid_q,  valid_d;
    logic                  sop_q,    sop_d;
    logic                  eop_q,    eop_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic                  xfer;
    logic [LEN_WIDTH-1:0]  next_n;

    // Pattern word for every lane of beat n under pattern mode m (mod 2^32).
    function automatic logic [DATA_WIDTH-1:0] beat_pattern(
        input logic [LEN_WIDTH-1:0] n,
        input logic [1:0]           m
    );
        logic [DATA_WIDTH-1:0] beat;
        logic [31:0]           n32;
        logic [31:0]           idx;
        logic [31:0]           lane;
        beat = '0;
        n32  = 32'(n);
        for (int unsigned k = 0; k < LANES; k++) begin
            idx = n32 * 32'(LANES) + 32'(k);
            case (m)
                2'd0:    lane = idx;
                2'd1:    lane = ~idx;
                2'd2:    lane = 32'd1 << 5'(n32 + 32'(k));
                default: lane = {n32[15:0], 16'(k)};
            endcase
            beat[32*k +: 32] = lane;
        end
        return beat;
    endfunction

    // Next-state and next-output logic; every register holds unless updated below.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mode_d  = mode_q;
        beats_d = beats_q;
        data_d  = data_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        xfer    = valid_q && ready;
        next_n  = beats_q + LEN_WIDTH'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    mode_d  = mode;
                    beats_d = '0;
                    if (len != '0) begin
                        // First beat is presented straight away, independent of ready.
                        state_d = S_RUN;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        data_d  = beat_pattern('0, mode);
                        sop_d   = 1'b1;
                        eop_d   = (len == LEN_WIDTH'(1));
                    end else begin
                        // Empty packet: report completion without emitting a beat.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (xfer) begin
                    beats_d = next_n;
                    if (eop_q) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        data_d  = '0;
                    end else begin
                        data_d  = beat_pattern(next_n, mode_q);
                        sop_d   = 1'b0;
                        eop_d   = (next_n == (len_q - LEN_WIDTH'(1)));
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            mode_q  <= '0;
            beats_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            beats_q <= beats_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign st_data    = data_q;
    assign valid      = valid_q;
    assign sop        = sop_q;
    assign eop        = eop_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign beats_sent = beats_q;

endmodule

// File: tb/tb_st_pattern_source.sv
// Scoreboard bench for st_pattern_source: stimulus queues expected beats and
// completion counts; a negedge monitor pops and compares on every transfer/done.
module tb_st_pattern_source;

    localparam int unsigned DW = 256;
    localparam int unsigned LW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic [1:0]    mode;
    logic [DW-1:0] st_data;
    logic          valid;
    logic          ready;
    logic          sop;
    logic          eop;
    logic          busy;
    logic          done;
    logic [LW-1:0] beats_sent;

    int    checks;
    int    failures;
    beat_t beat_q[$];
    int    done_q[$];
    int    ready_mode;
    int    pat[6];

    st_pattern_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode),
        .st_data(st_data), .valid(valid), .ready(ready), .sop(sop), .eop(eop),
        .busy(busy), .done(done), .beats_sent(beats_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference beat: lane words straight from the pattern definitions.
    function automatic beat_t mk_beat(input int n, input int l, input int m);
        beat_t       b;
        logic [31:0] w;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            case (m)
                0:       w = 32'(n * 8 + k);
                1:       w = ~32'(n * 8 + k);
                2:       w = 32'd1 << ((n + k) % 32);
                default: w = 32'(((n & 32'hffff) << 16) | k);
            endcase
            b.data[32*k +: 32] = w;
        end
        b.sop = (n == 0);
        b.eop = (n == l - 1);
        return b;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk_data({nm, "_data"}, st_data, '0);
        chk32({nm, "_valid"}, 32'(valid), 32'd0);
        chk32({nm, "_sop"}, 32'(sop), 32'd0);
        chk32({nm, "_eop"}, 32'(eop), 32'd0);
        chk32({nm, "_busy"}, 32'(busy), 32'd0);
        chk32({nm, "_done"}, 32'(done), 32'd0);
        chk32({nm, "_beats"}, 32'(beats_sent), 32'd0);
    endtask

    // Ready driver: low during and just after reset, then by policy.
    initial begin
        int post_rst;
        int pidx;
        pat = '{1, 0, 0, 1, 0, 1};
        pidx = 0;
        post_rst = 0;
        ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ready = 1'b0;
                post_rst = 2;
            end else if (post_rst > 0) begin
                ready = 1'b0;
                post_rst--;
            end else begin
                case (ready_mode)
                    0: ready = 1'b1;
                    1: ready = 1'($urandom_range(0, 1));
                    default: begin
                        ready = pat[pidx][0];
                        pidx = (pidx + 1) % 6;
                    end
                endcase
            end
        end
    end

    // Monitor: compare transfers and done pulses against the scoreboard.
    initial begin
        beat_t cur;
        beat_t held_b;
        beat_t exp_b;
        bit    held;
        bit    in_pkt;
        int    e;
        held = 0;
        in_pkt = 0;
        held_b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
                in_pkt = 0;
            end else begin
                cur.data = st_data;
                cur.sop  = sop;
                cur.eop  = eop;
                if (in_pkt || held)
                    chk32("valid_no_drop", 32'(valid), 32'd1);
                if (valid) begin
                    if (held) begin
                        chk_data("hold_data", cur.data, held_b.data);
                        chk32("hold_frame", {30'd0, cur.sop, cur.eop}, {30'd0, held_b.sop, held_b.eop});
                    end
                    if (ready) begin
                        checks++;
                        if (beat_q.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_beat actual=%h required=none", cur.data);
                        end else begin
                            exp_b = beat_q.pop_front();
                            if (cur !== exp_b) begin
                                failures++;
                                $display("FAIL beat actual=%h/sop%0b/eop%0b required=%h/sop%0b/eop%0b",
                                         cur.data, cur.sop, cur.eop, exp_b.data, exp_b.sop, exp_b.eop);
                            end
                        end
                        held = 0;
                        in_pkt = !cur.eop;
                    end else begin
                        held = 1;
                        held_b = cur;
                    end
                end else begin
                    held = 0;
                    in_pkt = 0;
                end
                if (done) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_done actual=1 required=0");
                    end else begin
                        e = done_q.pop_front();
                        chk32("done_beats", 32'(beats_sent), 32'(e));
                        chk32("done_valid", 32'(valid), 32'd0);
                        chk32("done_busy", 32'(busy), 32'd0);
                    end
                end
            end
        end
    end

    task automatic run_packet(input int l, input int m, input bit disturb);
        int cyc;
        for (int n = 0; n < l; n++) beat_q.push_back(mk_beat(n, l, m));
        done_q.push_back(l);
        @(posedge clk);
        #1;
        chk32("idle_valid", 32'(valid), 32'd0);
        chk32("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        len   = LW'(l);
        mode  = 2'(m);
        @(posedge clk);
        #1;
        start = 1'b0;
        len   = LW'($urandom);
        mode  = 2'($urandom);
        chk32("valid_rise", 32'(valid), 32'(l != 0));
        chk32("busy_rise", 32'(busy), 32'(l != 0));
        chk32("done_empty", 32'(done), 32'(l == 0));
        cyc = 0;
        while ((beat_q.size() != 0 || done_q.size() != 0) && cyc < 500) begin
            if (disturb && cyc == 2 && busy) begin
                start = 1'b1;
                len   = LW'($urandom_range(1, 9));
                mode  = 2'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 500) begin
            checks++;
            failures++;
            $display("FAIL packet_timeout actual=%0d_beats_left required=0", beat_q.size());
            beat_q.delete();
            done_q.delete();
        end
        chk32("final_beats", 32'(beats_sent), 32'(l));
        chk32("final_valid", 32'(valid), 32'd0);
        chk32("final_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int m;
        checks = 0;
        failures = 0;
        ready_mode = 0;
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        mode = '0;
        #3;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("post_reset");

        ready_mode = 0;
        run_packet(4, 0, 0);
        ready_mode = 2;
        run_packet(3, 1, 0);
        ready_mode = 0;
        run_packet(1, 2, 0);
        run_packet(0, 3, 0);
        ready_mode = 1;
        run_packet(5, 3, 1);
        run_packet(5, 1, 1);

        // Reset mid-packet after two accepted beats.
        ready_mode = 0;
        m = $urandom_range(0, 3);
        for (int n = 0; n < 6; n++) beat_q.push_back(mk_beat(n, 6, m));
        done_q.push_back(6);
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = LW'(6);
        mode  = 2'(m);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (beats_sent != LW'(2) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk32("reach_two", 32'(beats_sent), 32'd2);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        beat_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk32("no_done_after_rst", 32'(done), 32'd0);
            chk32("no_valid_after_rst", 32'(valid), 32'd0);
        end
        run_packet(2, m, 0);

        // Randomized packets under random backpressure.
        ready_mode = 1;
        for (int i = 0; i < 20; i++)
            run_packet($urandom_range(0, 12), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
